sc_gamectrl_multi: RTL and testbench
====================================

Name: sc_gamectrl_multi

Overview:
- Parametrised top-level Frogger game controller: the next generation of the game state machine.
- Owns the lives counter, level counter and per-house fill mask internally; the external comparators are no longer needed.
- Adds pause, restart-from-end, occupied-house detection and a timed inter-level transition.
- Sits between the input/collision datapath and the matrix/level loaders. Drives the same active-low strobes plus status buses.

Parameters:
- NUM_LIVES, 3, lives at game start (1..15).
- NUM_LEVELS, 4, levels to clear for a win (1..15).
- NUM_HOUSES, 5, goal houses per level (1..8).
- TRANS_CYCLES, 50000000, clock cycles spent in the inter-level transition (≥1).
- HOUSE_W, 3, width of the house index (≥ clog2(NUM_HOUSES)).

Ports:
- SC_GAMECTRL_CLOCK_50  in  1  system clock
- SC_GAMECTRL_RESET_InLow  in  1  asynchronous active-low reset
- SC_GAMECTRL_startButton_InLow  in  1  start/restart, synchronous level input
- SC_GAMECTRL_pauseButton_InLow  in  1  pause toggle, synchronous level input
- SC_GAMECTRL_Collision_InLow  in  1  frog hit/drowned, level input
- SC_GAMECTRL_HouseArrive_InLow  in  1  one-cycle low pulse when the frog reaches the goal row
- SC_GAMECTRL_HouseIndex_InBUS  in  HOUSE_W  house addressed by HouseArrive
- SC_GAMECTRL_StartGame_OutLow  out  1  one-cycle strobe: load start matrix
- SC_GAMECTRL_LoadGame_OutLow  out  1  one-cycle strobe: load next-level matrix
- SC_GAMECTRL_clearPoint_OutLow  out  1  one-cycle strobe: return frog to start
- SC_GAMECTRL_LifesSignal_OutLow  out  1  one-cycle strobe: life lost
- SC_GAMECTRL_LoadHouse_OutLow  out  1  one-cycle strobe: house filled
- SC_GAMECTRL_ClearLost_OutLow  out  1  one-cycle strobe: game ended, blank the playfield
- SC_GAMECTRL_Freeze_OutLow  out  1  low while PAUSE or TRANS: halts traffic movers
- SC_GAMECTRL_Lives_OutBUS  out  4  remaining lives
- SC_GAMECTRL_Level_OutBUS  out  4  current level, 0-based
- SC_GAMECTRL_HouseMask_OutBUS  out  NUM_HOUSES  filled houses, bit i = house i
- SC_GAMECTRL_Win_OutHigh  out  1  high in WIN
- SC_GAMECTRL_Lose_OutHigh  out  1  high in LOSE

Behaviour:
- Reset (async, RESET_InLow=0) values:
  - state=IDLE, Lives=NUM_LIVES, Level=0, HouseMask=0, timer=0.
  - All *_OutLow=1; Win=Lose=0.
  - Reset mid-game aborts immediately with no strobes.
- Button edge detection:
  - start and pause each pass through a registered falling-edge detector.
  - A press is acted on one cycle after the falling edge.
  - A held button produces one event only.
- Strobes: every *_OutLow strobe is exactly one cycle and decoded from the state (Moore).
- States and transitions:
  - IDLE: on start event -> START.
  - START: StartGame=0, clearPoint=0; Lives=NUM_LIVES, Level=0, HouseMask=0 -> PLAY.
  - PLAY, priority high to low:
    1. pause event -> PAUSE.
    2. Collision=0 -> LOSELIFE.
    3. HouseArrive=0 with index ≥ NUM_HOUSES, or the house already filled -> LOSELIFE.
    4. Valid HouseArrive -> HOUSE.
  - PAUSE: Freeze=0; collision and house inputs are ignored; pause event -> PLAY.
  - LOSELIFE: LifesSignal=0, clearPoint=0; Lives decrements. If old Lives==1 -> LOSE, else -> PLAY.
  - HOUSE: LoadHouse=0, clearPoint=0; sets the mask bit.
    - If the mask is now all ones: Level==NUM_LEVELS-1 -> WIN, else -> TRANS.
    - Otherwise -> PLAY.
  - TRANS: Freeze=0; the timer counts 0..TRANS_CYCLES-1, then -> NEXTLEVEL. Start/pause are ignored.
  - NEXTLEVEL: LoadGame=0, clearPoint=0; Level+1, HouseMask=0, timer=0 -> PLAY. Lives are not refilled.
  - WIN / LOSE: ClearLost=0 on the first cycle only (a one-cycle entry substate), then hold. A start event -> START (full restart).
- Arithmetic:
  - Lives never underflows: 0 is never reached while in PLAY.
  - Level saturates at NUM_LEVELS-1.
  - Timer width is clog2(TRANS_CYCLES+1).
- Simultaneous events: Collision and HouseArrive in the same cycle -> collision wins, the house is not filled. A pause event together with a collision -> PAUSE, and the collision is dropped.
- Any unused state encoding -> IDLE on the next clock, with all strobes high.

Test Plan:
1. Reset low then released; start pressed for 5 cycles -> exactly one StartGame=0 pulse and one clearPoint=0 pulse; Lives=3, Level=0, state PLAY.
2. Three Collision=0 pulses in PLAY -> three LifesSignal pulses, Lives goes 2,1,0→LOSE; ClearLost=0 for exactly 1 cycle; Lose=1; a further start press -> Lives=3.
3. HouseArrive on index 2, then index 2 again -> HouseMask=5'b00100 with LoadHouse pulse, then LifesSignal pulse; Lives=2 and mask unchanged.
4. Fill houses 0..4 on level 0 with TRANS_CYCLES=10 -> Freeze=0 for 10 cycles; LoadGame pulse; Level=1, HouseMask=0, Lives unchanged.
5. Pause press in PLAY followed by a Collision pulse -> no LifesSignal; Freeze=0; second pause press -> PLAY; Collision=0 now decrements Lives.
6. NUM_LEVELS=1: fill all houses -> WIN with one ClearLost pulse and Win=1. Assert reset mid-TRANS (set NUM_LEVELS=2 to reach TRANS) -> outputs immediately at their reset values.

Source files
------------

// File: rtl/sc_gamectrl_multi.sv
// Frogger game-state controller: owns lives, level and house-fill mask,
// sequences start/pause/life-loss/house/level-transition/end-of-game.
module sc_gamectrl_multi #(
    parameter int NUM_LIVES    = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int NUM_HOUSES   = 5,
    parameter int TRANS_CYCLES = 50000000,
    parameter int HOUSE_W      = 3
) (
    input  logic                  SC_GAMECTRL_CLOCK_50,
    input  logic                  SC_GAMECTRL_RESET_InLow,
    input  logic                  SC_GAMECTRL_startButton_InLow,
    input  logic                  SC_GAMECTRL_pauseButton_InLow,
    input  logic                  SC_GAMECTRL_Collision_InLow,
    input  logic                  SC_GAMECTRL_HouseArrive_InLow,
    input  logic [HOUSE_W-1:0]    SC_GAMECTRL_HouseIndex_InBUS,
    output logic                  SC_GAMECTRL_StartGame_OutLow,
    output logic                  SC_GAMECTRL_LoadGame_OutLow,
    output logic                  SC_GAMECTRL_clearPoint_OutLow,
    output logic                  SC_GAMECTRL_LifesSignal_OutLow,
    output logic                  SC_GAMECTRL_LoadHouse_OutLow,
    output logic                  SC_GAMECTRL_ClearLost_OutLow,
    output logic                  SC_GAMECTRL_Freeze_OutLow,
    output logic [3:0]            SC_GAMECTRL_Lives_OutBUS,
    output logic [3:0]            SC_GAMECTRL_Level_OutBUS,
    output logic [NUM_HOUSES-1:0] SC_GAMECTRL_HouseMask_OutBUS,
    output logic                  SC_GAMECTRL_Win_OutHigh,
    output logic                  SC_GAMECTRL_Lose_OutHigh
);

    localparam int                 TIMER_W    = $clog2(TRANS_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TRANS_CYCLES - 1);
    localparam logic [3:0]         LIVES_INIT = 4'(NUM_LIVES);
    localparam logic [3:0]         LEVEL_LAST = 4'(NUM_LEVELS - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_START      = 4'd1,
        S_PLAY       = 4'd2,
        S_PAUSE      = 4'd3,
        S_LOSELIFE   = 4'd4,
        S_HOUSE      = 4'd5,
        S_TRANS      = 4'd6,
        S_NEXTLEVEL  = 4'd7,
        S_WIN_ENTRY  = 4'd8,
        S_WIN        = 4'd9,
        S_LOSE_ENTRY = 4'd10,
        S_LOSE       = 4'd11
    } state_t;

    state_t                r_state, w_next;
    logic                  r_start_q, r_pause_q;
    logic                  r_start_evt, r_pause_evt;
    logic [3:0]            r_lives, r_level;
    logic [NUM_HOUSES-1:0] r_mask, r_house_oh;
    logic [TIMER_W-1:0]    r_timer;

    logic [NUM_HOUSES-1:0] w_arrive_oh, w_mask_set;
    logic                  w_arrive_bad;

    // Registered falling-edge detectors: a held button yields a single event
    // that the FSM sees one cycle after the edge.
    always_ff @(posedge SC_GAMECTRL_CLOCK_50 or negedge SC_GAMECTRL_RESET_InLow) begin
        if (!SC_GAMECTRL_RESET_InLow) begin
            r_start_q   <= 1'b1;
            r_pause_q   <= 1'b1;
            r_start_evt <= 1'b0;
            r_pause_evt <= 1'b0;
        end else begin
            r_start_q   <= SC_GAMECTRL_startButton_InLow;
            r_pause_q   <= SC_GAMECTRL_pauseButton_InLow;
            r_start_evt <= r_start_q & ~SC_GAMECTRL_startButton_InLow;
            r_pause_evt <= r_pause_q & ~SC_GAMECTRL_pauseButton_InLow;
        end
    end

    // An out-of-range index decodes to an all-zero one-hot, which is treated
    // the same as landing on an already-filled house.
    always_comb begin
        w_arrive_oh = '0;
        for (int h = 0; h < NUM_HOUSES; h++)
            if (SC_GAMECTRL_HouseIndex_InBUS == HOUSE_W'(h)) w_arrive_oh[h] = 1'b1;
    end

    assign w_arrive_bad = ~(|w_arrive_oh) | (|(w_arrive_oh & r_mask));
    assign w_mask_set   = r_mask | r_house_oh;

    always_ff @(posedge SC_GAMECTRL_CLOCK_50 or negedge SC_GAMECTRL_RESET_InLow) begin
        if (!SC_GAMECTRL_RESET_InLow) r_state <= S_IDLE;
        else                          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (r_start_evt) w_next = S_START;
            S_START:    w_next = S_PLAY;
            S_PLAY: begin
                if (r_pause_evt)                             w_next = S_PAUSE;
                else if (!SC_GAMECTRL_Collision_InLow)       w_next = S_LOSELIFE;
                else if (!SC_GAMECTRL_HouseArrive_InLow)
                    w_next = w_arrive_bad ? S_LOSELIFE : S_HOUSE;
            end
            S_PAUSE:    if (r_pause_evt) w_next = S_PLAY;
            S_LOSELIFE: w_next = (r_lives <= 4'd1) ? S_LOSE_ENTRY : S_PLAY;
            S_HOUSE: begin
                if (&w_mask_set) w_next = (r_level == LEVEL_LAST) ? S_WIN_ENTRY : S_TRANS;
                else             w_next = S_PLAY;
            end
            S_TRANS:      if (r_timer == TIMER_LAST) w_next = S_NEXTLEVEL;
            S_NEXTLEVEL:  w_next = S_PLAY;
            S_WIN_ENTRY:  w_next = S_WIN;
            S_WIN:        if (r_start_evt) w_next = S_START;
            S_LOSE_ENTRY: w_next = S_LOSE;
            S_LOSE:       if (r_start_evt) w_next = S_START;
            default:      w_next = S_IDLE;
        endcase
    end

    // Game counters advance on the state being occupied, so each update
    // coincides with the matching one-cycle strobe.
    always_ff @(posedge SC_GAMECTRL_CLOCK_50 or negedge SC_GAMECTRL_RESET_InLow) begin
        if (!SC_GAMECTRL_RESET_InLow) begin
            r_lives    <= LIVES_INIT;
            r_level    <= '0;
            r_mask     <= '0;
            r_house_oh <= '0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                S_START: begin
                    r_lives <= LIVES_INIT;
                    r_level <= '0;
                    r_mask  <= '0;
                    r_timer <= '0;
                end
                S_PLAY:     r_house_oh <= w_arrive_oh;
                S_LOSELIFE: if (r_lives != 4'd0) r_lives <= r_lives - 4'd1;
                S_HOUSE:    r_mask <= w_mask_set;
                S_TRANS:    if (r_timer != TIMER_LAST) r_timer <= r_timer + 1'b1;
                S_NEXTLEVEL: begin
                    if (r_level < LEVEL_LAST) r_level <= r_level + 4'd1;
                    r_mask  <= '0;
                    r_timer <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SC_GAMECTRL_StartGame_OutLow   = 1'b1;
        SC_GAMECTRL_LoadGame_OutLow    = 1'b1;
        SC_GAMECTRL_clearPoint_OutLow  = 1'b1;
        SC_GAMECTRL_LifesSignal_OutLow = 1'b1;
        SC_GAMECTRL_LoadHouse_OutLow   = 1'b1;
        SC_GAMECTRL_ClearLost_OutLow   = 1'b1;
        SC_GAMECTRL_Freeze_OutLow      = 1'b1;
        SC_GAMECTRL_Win_OutHigh        = 1'b0;
        SC_GAMECTRL_Lose_OutHigh       = 1'b0;
        case (r_state)
            S_START: begin
                SC_GAMECTRL_StartGame_OutLow  = 1'b0;
                SC_GAMECTRL_clearPoint_OutLow = 1'b0;
            end
            S_PAUSE, S_TRANS: SC_GAMECTRL_Freeze_OutLow = 1'b0;
            S_LOSELIFE: begin
                SC_GAMECTRL_LifesSignal_OutLow = 1'b0;
                SC_GAMECTRL_clearPoint_OutLow  = 1'b0;
            end
            S_HOUSE: begin
                SC_GAMECTRL_LoadHouse_OutLow  = 1'b0;
                SC_GAMECTRL_clearPoint_OutLow = 1'b0;
            end
            S_NEXTLEVEL: begin
                SC_GAMECTRL_LoadGame_OutLow   = 1'b0;
                SC_GAMECTRL_clearPoint_OutLow = 1'b0;
            end
            S_WIN_ENTRY: begin
                SC_GAMECTRL_ClearLost_OutLow = 1'b0;
                SC_GAMECTRL_Win_OutHigh      = 1'b1;
            end
            S_WIN:       SC_GAMECTRL_Win_OutHigh = 1'b1;
            S_LOSE_ENTRY: begin
                SC_GAMECTRL_ClearLost_OutLow = 1'b0;
                SC_GAMECTRL_Lose_OutHigh     = 1'b1;
            end
            S_LOSE:      SC_GAMECTRL_Lose_OutHigh = 1'b1;
            default: ;
        endcase
    end

    assign SC_GAMECTRL_Lives_OutBUS     = r_lives;
    assign SC_GAMECTRL_Level_OutBUS     = r_level;
    assign SC_GAMECTRL_HouseMask_OutBUS = r_mask;

endmodule

// File: tb/tb_sc_gamectrl_multi.sv
// Self-checking bench for sc_gamectrl_multi: directed scenarios plus
// randomized games checked against a rule-level game model.
module tb_sc_gamectrl_multi;

    localparam int NL = 3, NLV = 2, NH = 5, TC = 10, HW = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start_n = 1'b1, pause_n = 1'b1, coll_n = 1'b1, arr_n = 1'b1;
    logic [HW-1:0] idx = '0;
    logic sg_n, lg_n, cp_n, ls_n, lh_n, cl_n, fz_n, win, lose;
    logic [3:0] lives, level;
    logic [NH-1:0] mask;

    int tests = 0, fails = 0;
    int cnt_sg = 0, cnt_lg = 0, cnt_cp = 0, cnt_ls = 0, cnt_lh = 0, cnt_cl = 0, cnt_fz = 0;

    always #5 clk = ~clk;

    sc_gamectrl_multi #(.NUM_LIVES(NL), .NUM_LEVELS(NLV), .NUM_HOUSES(NH),
                        .TRANS_CYCLES(TC), .HOUSE_W(HW)) dut (
        .SC_GAMECTRL_CLOCK_50(clk),
        .SC_GAMECTRL_RESET_InLow(rst_n),
        .SC_GAMECTRL_startButton_InLow(start_n),
        .SC_GAMECTRL_pauseButton_InLow(pause_n),
        .SC_GAMECTRL_Collision_InLow(coll_n),
        .SC_GAMECTRL_HouseArrive_InLow(arr_n),
        .SC_GAMECTRL_HouseIndex_InBUS(idx),
        .SC_GAMECTRL_StartGame_OutLow(sg_n),
        .SC_GAMECTRL_LoadGame_OutLow(lg_n),
        .SC_GAMECTRL_clearPoint_OutLow(cp_n),
        .SC_GAMECTRL_LifesSignal_OutLow(ls_n),
        .SC_GAMECTRL_LoadHouse_OutLow(lh_n),
        .SC_GAMECTRL_ClearLost_OutLow(cl_n),
        .SC_GAMECTRL_Freeze_OutLow(fz_n),
        .SC_GAMECTRL_Lives_OutBUS(lives),
        .SC_GAMECTRL_Level_OutBUS(level),
        .SC_GAMECTRL_HouseMask_OutBUS(mask),
        .SC_GAMECTRL_Win_OutHigh(win),
        .SC_GAMECTRL_Lose_OutHigh(lose)
    );

    // Low-cycle counters for every strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (!sg_n) cnt_sg <= cnt_sg + 1;
        if (!lg_n) cnt_lg <= cnt_lg + 1;
        if (!cp_n) cnt_cp <= cnt_cp + 1;
        if (!ls_n) cnt_ls <= cnt_ls + 1;
        if (!lh_n) cnt_lh <= cnt_lh + 1;
        if (!cl_n) cnt_cl <= cnt_cl + 1;
        if (!fz_n) cnt_fz <= cnt_fz + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start(input int hold);
        start_n = 1'b0; tick(hold); start_n = 1'b1; tick(6);
    endtask

    task automatic press_pause(input int hold);
        pause_n = 1'b0; tick(hold); pause_n = 1'b1; tick(4);
    endtask

    task automatic collide();
        coll_n = 1'b0; tick(1); coll_n = 1'b1; tick(4);
    endtask

    task automatic arrive(input int h, input int settle);
        idx = HW'(h); arr_n = 1'b0; tick(1); arr_n = 1'b1; tick(settle);
    endtask

    task automatic restart();
        @(negedge clk); rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        press_start(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        tests++;
        if ({sg_n, lg_n, cp_n, ls_n, lh_n, cl_n, fz_n, win, lose} !== 9'b111111100) begin
            fails++; $display("FAIL reset_strobes got=%b want=111111100",
                              {sg_n, lg_n, cp_n, ls_n, lh_n, cl_n, fz_n, win, lose});
        end
        tests++;
        if ({lives, level, mask} !== {4'd3, 4'd0, 5'd0}) begin
            fails++; $display("FAIL reset_buses lives=%0d level=%0d mask=%b", lives, level, mask);
        end
        rst_n = 1'b1; tick(3);
    endtask

    task automatic test_start();
        int sg0, cp0;
        sg0 = cnt_sg; cp0 = cnt_cp;
        press_start(5);
        tick(4);
        tests++;
        if (cnt_sg - sg0 !== 1) begin
            fails++; $display("FAIL start_pulses got=%0d want=1", cnt_sg - sg0);
        end
        tests++;
        if (cnt_cp - cp0 !== 1) begin
            fails++; $display("FAIL start_clearpoint got=%0d want=1", cnt_cp - cp0);
        end
        tests++;
        if ({lives, level, fz_n, win, lose} !== {4'd3, 4'd0, 3'b100}) begin
            fails++; $display("FAIL start_state lives=%0d level=%0d fz=%b", lives, level, fz_n);
        end
    endtask

    task automatic test_lose();
        int ls0, cl0;
        ls0 = cnt_ls;
        for (int k = 1; k <= 3; k++) begin
            collide();
            tests++;
            if (lives !== 4'(3 - k)) begin
                fails++; $display("FAIL lose_lives step=%0d got=%0d want=%0d", k, lives, 3 - k);
            end
        end
        cl0 = cnt_cl - ((cl_n == 1'b0) ? 0 : 0);
        tick(10);
        tests++;
        if (cnt_ls - ls0 !== 3) begin
            fails++; $display("FAIL lose_lifesignal got=%0d want=3", cnt_ls - ls0);
        end
        tests++;
        if (lose !== 1'b1 || win !== 1'b0) begin
            fails++; $display("FAIL lose_flag lose=%b win=%b want lose=1 win=0", lose, win);
        end
        cl0 = cnt_cl;
        tick(5);
        tests++;
        if (cnt_cl !== cl0 || cl0 < 1) begin
            fails++; $display("FAIL lose_clearlost total=%0d want exactly one, stable", cnt_cl);
        end
        press_start(3);
        tests++;
        if (lives !== 4'd3 || lose !== 1'b0) begin
            fails++; $display("FAIL lose_restart lives=%0d lose=%b want 3,0", lives, lose);
        end
    endtask

    task automatic test_house_repeat();
        int lh0, ls0;
        restart();
        lh0 = cnt_lh; ls0 = cnt_ls;
        arrive(2, 4);
        tests++;
        if (mask !== 5'b00100 || cnt_lh - lh0 !== 1) begin
            fails++; $display("FAIL house_fill mask=%b loads=%0d want 00100,1", mask, cnt_lh - lh0);
        end
        arrive(2, 4);
        tests++;
        if (mask !== 5'b00100 || lives !== 4'd2 || cnt_ls - ls0 !== 1 || cnt_lh - lh0 !== 1) begin
            fails++; $display("FAIL house_repeat mask=%b lives=%0d ls=%0d lh=%0d want 00100,2,1,1",
                              mask, lives, cnt_ls - ls0, cnt_lh - lh0);
        end
        arrive(6, 4);
        tests++;
        if (mask !== 5'b00100 || lives !== 4'd1) begin
            fails++; $display("FAIL house_range mask=%b lives=%0d want 00100,1", mask, lives);
        end
    endtask

    task automatic test_level_trans();
        int fz0, lg0;
        restart();
        fz0 = cnt_fz; lg0 = cnt_lg;
        for (int h = 0; h < NH; h++) arrive(h, (h == NH - 1) ? 20 : 4);
        tests++;
        if (cnt_fz - fz0 !== TC) begin
            fails++; $display("FAIL trans_freeze got=%0d want=%0d", cnt_fz - fz0, TC);
        end
        tests++;
        if (cnt_lg - lg0 !== 1) begin
            fails++; $display("FAIL trans_loadgame got=%0d want=1", cnt_lg - lg0);
        end
        tests++;
        if ({level, mask, lives, fz_n} !== {4'd1, 5'd0, 4'd3, 1'b1}) begin
            fails++; $display("FAIL trans_state level=%0d mask=%b lives=%0d fz=%b", level, mask, lives, fz_n);
        end
    endtask

    task automatic test_pause();
        int ls0;
        restart();
        ls0 = cnt_ls;
        press_pause(3);
        collide();
        tests++;
        if (fz_n !== 1'b0 || lives !== 4'd3 || cnt_ls !== ls0) begin
            fails++; $display("FAIL pause_ignore fz=%b lives=%0d ls=%0d want 0,3,0", fz_n, lives, cnt_ls - ls0);
        end
        arrive(1, 4);
        tests++;
        if (mask !== 5'd0) begin
            fails++; $display("FAIL pause_house mask=%b want 00000", mask);
        end
        press_pause(4);
        tests++;
        if (fz_n !== 1'b1) begin
            fails++; $display("FAIL pause_resume fz=%b want 1", fz_n);
        end
        collide();
        tests++;
        if (lives !== 4'd2 || cnt_ls - ls0 !== 1) begin
            fails++; $display("FAIL pause_after lives=%0d ls=%0d want 2,1", lives, cnt_ls - ls0);
        end
        // Collision and arrival together: the house must stay empty.
        coll_n = 1'b0; idx = 3'd0; arr_n = 1'b0; tick(1); coll_n = 1'b1; arr_n = 1'b1; tick(4);
        tests++;
        if (lives !== 4'd1 || mask !== 5'd0) begin
            fails++; $display("FAIL simul_event lives=%0d mask=%b want 1,00000", lives, mask);
        end
    endtask

    task automatic test_win_and_reset();
        int cl0;
        restart();
        cl0 = cnt_cl;
        for (int h = 0; h < NH; h++) arrive(h, (h == NH - 1) ? 20 : 4);
        for (int h = NH - 1; h >= 0; h--) arrive(h, 4);
        tick(6);
        tests++;
        if (win !== 1'b1 || lose !== 1'b0 || cnt_cl - cl0 !== 1) begin
            fails++; $display("FAIL win_state win=%b lose=%b cl=%0d want 1,0,1", win, lose, cnt_cl - cl0);
        end
        press_start(2);
        tests++;
        if ({win, lives, level, mask} !== {1'b0, 4'd3, 4'd0, 5'd0}) begin
            fails++; $display("FAIL win_restart win=%b lives=%0d level=%0d mask=%b", win, lives, level, mask);
        end
        for (int h = 0; h < NH; h++) arrive(h, (h == NH - 1) ? 3 : 4);
        tests++;
        if (fz_n !== 1'b0 || mask !== 5'b11111) begin
            fails++; $display("FAIL pre_reset fz=%b mask=%b want 0,11111", fz_n, mask);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({sg_n, lg_n, cp_n, ls_n, lh_n, cl_n, fz_n, win, lose, lives, level, mask} !==
            {9'b111111100, 4'd3, 4'd0, 5'd0}) begin
            fails++; $display("FAIL midtrans_reset fz=%b lives=%0d level=%0d mask=%b", fz_n, lives, level, mask);
        end
        tick(2); rst_n = 1'b1; tick(2);
    endtask

    // Rule-level model: lives/level/mask and pulse totals over random games.
    task automatic test_random_games();
        for (int g = 0; g < 4; g++) begin
            int m_lives, m_level, m_mask, m_ls, m_lh, ls0, lh0, h, sel;
            bit over, m_win;
            restart();
            m_lives = NL; m_level = 0; m_mask = 0; m_ls = 0; m_lh = 0; over = 0; m_win = 0;
            ls0 = cnt_ls; lh0 = cnt_lh;
            for (int e = 0; e < 40 && !over; e++) begin
                sel = $urandom_range(0, 99);
                if (sel < 12) begin
                    collide();
                    m_lives--; m_ls++;
                end else begin
                    if (sel < 80) begin
                        h = $urandom_range(0, NH - 1);
                        while (m_mask[h]) h = (h + 1) % NH;
                    end else h = $urandom_range(0, 7);
                    if (h >= NH || m_mask[h]) begin
                        arrive(h, 4);
                        m_lives--; m_ls++;
                    end else begin
                        m_mask |= (1 << h); m_lh++;
                        if (m_mask == (1 << NH) - 1) begin
                            if (m_level == NLV - 1) begin
                                arrive(h, 4); over = 1; m_win = 1;
                            end else begin
                                arrive(h, TC + 8); m_level++; m_mask = 0;
                            end
                        end else arrive(h, 4);
                    end
                end
                if (m_lives == 0) over = 1;
                tests++;
                if (lives !== 4'(m_lives) || level !== 4'(m_level) || mask !== NH'(m_mask)) begin
                    fails++; $display("FAIL rand_state g=%0d e=%0d got %0d/%0d/%b want %0d/%0d/%b",
                                      g, e, lives, level, mask, m_lives, m_level, NH'(m_mask));
                end
            end
            tests++;
            if (cnt_ls - ls0 !== m_ls || cnt_lh - lh0 !== m_lh ||
                win !== (over && m_win) || lose !== (over && !m_win)) begin
                fails++; $display("FAIL rand_end g=%0d ls=%0d/%0d lh=%0d/%0d win=%b lose=%b",
                                  g, cnt_ls - ls0, m_ls, cnt_lh - lh0, m_lh, win, lose);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lose();
        test_house_repeat();
        test_level_trans();
        test_pause();
        test_win_and_reset();
        test_random_games();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
